// File: rtl/grid_template_param.sv
// grid_template_param
//
// Grid overlay generator for the VGA pipeline. It follows the raw pixel
// counters hc/vc and reports which grid cell the current pixel falls in. It
// also reports whether the pixel is inside the grid rectangle, whether it lies
// on a divider/border line of LINE_W pixels, and (optionally) whether it lies
// in a selected cell. Cell position is tracked with running offset counters,
// so any cell size and column/row count works without comparator chains.
//
// Optional feature macro: GRID_HIGHLIGHT_EN
//   defined   -> cell_sel = in_grid & (col == sel_x) & (row == sel_y)
//   undefined -> cell_sel tied to 0, sel_x/sel_y ignored (ports kept)
//
// Ports:
//   clk       in   pixel clock
//   rst       in   asynchronous active-high reset
//   hc, vc    in   11-bit horizontal / vertical pixel counters
//   sel_x     in   highlighted column (CX_W bits)
//   sel_y     in   highlighted row (CY_W bits)
//   matrix_x  out  column index of the pixel (0 outside the grid)
//   matrix_y  out  row index of the pixel (0 outside the grid)
//   in_grid   out  pixel is inside the grid rectangle of a tracked frame
//   lines     out  pixel is on a divider or border line
//   cell_sel  out  pixel is inside the highlighted cell
//
// All outputs are registered: values at cycle t+1 describe hc/vc at cycle t.
module grid_template_param #(
  parameter int GRID_XI = 212,
  parameter int GRID_YI = 184,
  parameter int CELL_W  = 100,
  parameter int CELL_H  = 100,
  parameter int N_COLS  = 6,
  parameter int N_ROWS  = 4,
  parameter int LINE_W  = 1,
  localparam int CX_W   = (N_COLS > 1) ? $clog2(N_COLS) : 1,
  localparam int CY_W   = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [10:0]     hc,
  input  logic [10:0]     vc,
  input  logic [CX_W-1:0] sel_x,
  input  logic [CY_W-1:0] sel_y,
  output logic [CX_W-1:0] matrix_x,
  output logic [CY_W-1:0] matrix_y,
  output logic            in_grid,
  output logic            lines,
  output logic            cell_sel
);

  localparam int XO_W    = $clog2(CELL_W);
  localparam int YO_W    = $clog2(CELL_H);
  localparam int GRID_XF = GRID_XI + N_COLS * CELL_W - 1;
  localparam int GRID_YF = GRID_YI + N_ROWS * CELL_H - 1;

  localparam logic [10:0]     XI_C       = 11'(GRID_XI);
  localparam logic [10:0]     XF_C       = 11'(GRID_XF);
  localparam logic [10:0]     YI_C       = 11'(GRID_YI);
  localparam logic [10:0]     YF_C       = 11'(GRID_YF);
  localparam logic [XO_W-1:0] XO_LAST    = XO_W'(CELL_W - 1);
  localparam logic [YO_W-1:0] YO_LAST    = YO_W'(CELL_H - 1);
  localparam logic [XO_W-1:0] XO_LW      = XO_W'(LINE_W);
  localparam logic [YO_W-1:0] YO_LW      = YO_W'(LINE_W);
  localparam logic [XO_W-1:0] XO_LINE_HI = XO_W'(CELL_W - LINE_W);
  localparam logic [YO_W-1:0] YO_LINE_HI = YO_W'(CELL_H - LINE_W);
  localparam logic [CX_W-1:0] LAST_COL   = CX_W'(N_COLS - 1);
  localparam logic [CY_W-1:0] LAST_ROW   = CY_W'(N_ROWS - 1);

  // Tracking state: position of the previously presented pixel.
  logic [CX_W-1:0] col_p1;
  logic [XO_W-1:0] xoff_p1;
  logic [CY_W-1:0] row_p1;
  logic [YO_W-1:0] yoff_p1;
  logic            synced_p1;

  // Position of the pixel currently on hc/vc.
  logic [CX_W-1:0] col_p0;
  logic [XO_W-1:0] xoff_p0;
  logic [CY_W-1:0] row_p0;
  logic [YO_W-1:0] yoff_p0;
  logic            synced_p0;
  logic            in_grid_p0;
  logic            lines_p0;

  logic x_start;
  logic x_span;
  logic x_in;
  logic y_in;

  assign x_start = (hc == XI_C);
  assign x_span  = (hc > XI_C) && (hc <= XF_C);
  assign x_in    = (hc >= XI_C) && (hc <= XF_C);
  assign y_in    = (vc >= YI_C) && (vc <= YF_C);

  // ---- Stage p0: derive current pixel position from previous state ----
  always_comb begin
    col_p0  = '0;
    xoff_p0 = '0;
    if (x_span) begin
      if (xoff_p1 == XO_LAST) begin
        xoff_p0 = '0;
        col_p0  = col_p1 + CX_W'(1);
      end else begin
        xoff_p0 = xoff_p1 + XO_W'(1);
        col_p0  = col_p1;
      end
    end
  end

  // Row state only moves once per line, on the first grid pixel of the line.
  // Lines above the grid and below it both park row/yoff at 0.
  always_comb begin
    row_p0    = row_p1;
    yoff_p0   = yoff_p1;
    synced_p0 = synced_p1;
    if (x_start) begin
      if (vc == YI_C) begin
        row_p0    = '0;
        yoff_p0   = '0;
        synced_p0 = 1'b1;
      end else if ((vc > YI_C) && (vc <= YF_C)) begin
        if (yoff_p1 == YO_LAST) begin
          yoff_p0 = '0;
          row_p0  = row_p1 + CY_W'(1);
        end else begin
          yoff_p0 = yoff_p1 + YO_W'(1);
        end
      end else begin
        row_p0  = '0;
        yoff_p0 = '0;
      end
    end
  end

  assign in_grid_p0 = synced_p0 && x_in && y_in;

  // Leading lines at the start of every cell; trailing border only on the
  // last column / last row so the grid is closed on the right and bottom.
  assign lines_p0 = in_grid_p0 &&
                    ((xoff_p0 < XO_LW) ||
                     (yoff_p0 < YO_LW) ||
                     ((col_p0 == LAST_COL) && (xoff_p0 >= XO_LINE_HI)) ||
                     ((row_p0 == LAST_ROW) && (yoff_p0 >= YO_LINE_HI)));

  // ---- Stage p1: registered state and outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_p1    <= '0;
      xoff_p1   <= '0;
      row_p1    <= '0;
      yoff_p1   <= '0;
      synced_p1 <= 1'b0;
      matrix_x  <= '0;
      matrix_y  <= '0;
      in_grid   <= 1'b0;
      lines     <= 1'b0;
    end else begin
      col_p1    <= col_p0;
      xoff_p1   <= xoff_p0;
      row_p1    <= row_p0;
      yoff_p1   <= yoff_p0;
      synced_p1 <= synced_p0;
      matrix_x  <= in_grid_p0 ? col_p0 : '0;
      matrix_y  <= in_grid_p0 ? row_p0 : '0;
      in_grid   <= in_grid_p0;
      lines     <= lines_p0;
    end
  end

`ifdef GRID_HIGHLIGHT_EN
  logic cell_sel_p0;

  assign cell_sel_p0 = in_grid_p0 && (col_p0 == sel_x) && (row_p0 == sel_y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cell_sel <= 1'b0;
    end else begin
      cell_sel <= cell_sel_p0;
    end
  end
`else
  logic unused_sel;

  assign unused_sel = ^{sel_x, sel_y};
  assign cell_sel   = 1'b0;
`endif

endmodule

// File: tb/tb_grid_template_param.sv
module tb_grid_template_param;

`ifdef GRID_HIGHLIGHT_EN
  localparam bit HL = 1'b1;
`else
  localparam bit HL = 1'b0;
`endif

  typedef struct packed {
    logic       ig;
    logic [2:0] mx;
    logic [1:0] my;
    logic       ln;
    logic       cs;
  } exp_t;

  typedef struct {
    exp_t e1;
    exp_t e2;
    bit   chk;
    int   h;
    int   v;
  } sb_t;

  logic        clk;
  logic        rst;
  logic [10:0] hc;
  logic [10:0] vc;
  logic [2:0]  sel_x;
  logic [1:0]  sel_y;

  logic [2:0]  mx1;
  logic [1:0]  my1;
  logic        ig1, ln1, cs1;
  logic [1:0]  mx2;
  logic [1:0]  my2;
  logic        ig2, ln2, cs2;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  bit synced_m = 1'b0;
  sb_t sb[$];

  // Default configuration.
  grid_template_param dut1 (
    .clk(clk), .rst(rst), .hc(hc), .vc(vc),
    .sel_x(sel_x), .sel_y(sel_y),
    .matrix_x(mx1), .matrix_y(my1),
    .in_grid(ig1), .lines(ln1), .cell_sel(cs1)
  );

  // Thick lines, 3 narrow columns.
  grid_template_param #(.LINE_W(3), .N_COLS(3), .CELL_W(40)) dut2 (
    .clk(clk), .rst(rst), .hc(hc), .vc(vc),
    .sel_x(sel_x[1:0]), .sel_y(sel_y),
    .matrix_x(mx2), .matrix_y(my2),
    .in_grid(ig2), .lines(ln2), .cell_sel(cs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: position by division from the grid origin.
  function automatic exp_t model(input int h, input int v, input bit syn,
                                 input int sx, input int sy,
                                 input int cw, input int ncol, input int lw);
    exp_t e;
    int xf, yf, c, r, xo, yo;
    e  = '0;
    xf = 212 + ncol * cw - 1;
    yf = 184 + 4 * 100 - 1;
    if (syn && h >= 212 && h <= xf && v >= 184 && v <= yf) begin
      c  = (h - 212) / cw;
      xo = (h - 212) % cw;
      r  = (v - 184) / 100;
      yo = (v - 184) % 100;
      e.ig = 1'b1;
      e.mx = 3'(c);
      e.my = 2'(r);
      e.ln = (xo < lw) || (yo < lw) ||
             (c == ncol - 1 && xo >= cw - lw) ||
             (r == 3 && yo >= 100 - lw);
      e.cs = HL && (c == sx) && (r == sy);
    end
    return e;
  endfunction

  task automatic step(input int h, input int v, input bit chk);
    sb_t  ent;
    exp_t o1, o2;
    hc = 11'(h);
    vc = 11'(v);
    if (h == 212 && v == 184) synced_m = 1'b1;
    ent.e1  = model(h, v, synced_m, int'(sel_x), int'(sel_y), 100, 6, 1);
    ent.e2  = model(h, v, synced_m, int'(sel_x[1:0]), int'(sel_y), 40, 3, 3);
    ent.chk = chk;
    ent.h   = h;
    ent.v   = v;
    sb.push_back(ent);
    @(posedge clk);
    #1;
    ent = sb.pop_front();
    if (ent.chk) begin
      o1 = {ig1, mx1, my1, ln1, cs1};
      o2 = {ig2, {1'b0, mx2}, my2, ln2, cs2};
      chk_cnt++;
      if (o1 !== ent.e1)
        $display("FAIL pix_default hc=%0d vc=%0d got ig,mx,my,ln,cs=%b required %b",
                 ent.h, ent.v, o1, ent.e1);
      else pass_cnt++;
      chk_cnt++;
      if (o2 !== ent.e2)
        $display("FAIL pix_thick hc=%0d vc=%0d got ig,mx,my,ln,cs=%b required %b",
                 ent.h, ent.v, o2, ent.e2);
      else pass_cnt++;
    end
  endtask

  task automatic sweep(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) step(h, v, 1'b1);
  endtask

  // One pixel per line at the grid origin column: keeps rows advancing.
  task automatic skip_lines(input int v0, input int v1);
    for (int v = v0; v <= v1; v++) step(212, v, 1'b1);
  endtask

  task automatic pulse_reset(input string name);
    exp_t o1, o2;
    rst = 1'b1;
    synced_m = 1'b0;
    #1;
    o1 = {ig1, mx1, my1, ln1, cs1};
    o2 = {ig2, {1'b0, mx2}, my2, ln2, cs2};
    chk_cnt++;
    if (o1 !== '0) $display("FAIL %s_default got %b required 0", name, o1);
    else pass_cnt++;
    chk_cnt++;
    if (o2 !== '0) $display("FAIL %s_thick got %b required 0", name, o2);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    hc = 11'd0;
    vc = 11'd0;
    sel_x = 3'd0;
    sel_y = 2'd0;
    @(posedge clk);
    #1;
    pulse_reset("reset");
    // Grid pixels before any frame start must not be shown.
    sweep(200, 210, 214);
  endtask

  task automatic test_frame_start();
    sweep(184, 208, 216);
    skip_lines(185, 249);
  endtask

  task automatic test_column_boundary();
    sweep(250, 208, 320);
    skip_lines(251, 329);
  endtask

  task automatic test_highlight();
    sel_x = 3'd2;
    sel_y = 2'd1;
    sweep(330, 212, 460);
    sel_x = 3'd3;
    sweep(331, 212, 460);
    sel_x = 3'd0;
    sel_y = 2'd0;
    skip_lines(332, 582);
  endtask

  task automatic test_edges();
    sweep(583, 212, 815);
    sweep(584, 210, 300);
  endtask

  task automatic test_mid_reset();
    skip_lines(184, 299);
    sweep(300, 212, 260);
    pulse_reset("mid_reset");
    skip_lines(300, 349);
    sweep(350, 212, 420);
    skip_lines(351, 600);
    sweep(184, 210, 220);
    skip_lines(185, 190);
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_frame_start();
    test_column_boundary();
    test_highlight();
    test_edges();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/grid_template_param.md
# grid_template_param

Parametrised grid overlay generator for the VGA pipeline. It takes the raw pixel counters `hc`/`vc` and a pixel-rate clock, and produces the grid cell index of the current pixel. It also produces an in-grid flag, a divider-line mask of configurable thickness, and an optional selected-cell highlight. Cell position is tracked with per-pixel offset counters, not comparator chains, so any column count, row count and cell size is supported. It sits between the VGA timing generator and the pixel colour mux.

## Interface
- `GRID_XI`, 212: first visible `hc` of the grid (inclusive).
- `GRID_YI`, 184: first visible `vc` of the grid (inclusive).
- `CELL_W`, 100: cell width in pixels, ≥ 2.
- `CELL_H`, 100: cell height in pixels, ≥ 2.
- `N_COLS`, 6: number of columns, ≥ 1.
- `N_ROWS`, 4: number of rows, ≥ 1.
- `LINE_W`, 1: divider line thickness in pixels, 1 ≤ `LINE_W` < min(`CELL_W`, `CELL_H`).
- Derived values:
  - `CX_W` = max(1, $clog2(`N_COLS`)); `CY_W` = max(1, $clog2(`N_ROWS`)).
  - `GRID_XF` = `GRID_XI` + `N_COLS`·`CELL_W` − 1; `GRID_YF` = `GRID_YI` + `N_ROWS`·`CELL_H` − 1.

Ports:
- `clk`, in, 1: pixel clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `hc`, in, 11: horizontal pixel counter.
- `vc`, in, 11: vertical pixel counter.
- `sel_x`, in, `CX_W`: highlighted column.
- `sel_y`, in, `CY_W`: highlighted row.
- `matrix_x`, out, `CX_W`: column index of the pixel.
- `matrix_y`, out, `CY_W`: row index of the pixel.
- `in_grid`, out, 1: pixel lies inside the grid rectangle.
- `lines`, out, 1: pixel lies on a divider or border line.
- `cell_sel`, out, 1: pixel lies in the highlighted cell.

## Operation
- Environment requirements:
  - `hc` increments by 1 every `clk` cycle across the grid span.
  - `vc` increments by 1 between consecutive lines.
  - The violation case is specified only for the following: if `hc` jumps inside a line, outputs are undefined until the next `hc == GRID_XI`.
- X tracking:
  - At `hc == GRID_XI`, load `col = 0`, `xoff = 0`.
  - For `GRID_XI < hc ≤ GRID_XF`, increment `xoff`. When `xoff` reaches `CELL_W − 1`, wrap it to 0 and increment `col`.
  - Outside this span, hold `col = 0`, `xoff = 0`.
- Y tracking, updated once per line at `hc == GRID_XI`:
  - If `vc == GRID_YI`, load `row = 0`, `yoff = 0`, and set `synced`.
  - Else if `GRID_YI < vc ≤ GRID_YF`, increment `yoff`. When `yoff` reaches `CELL_H − 1`, wrap it to 0 and increment `row`.
  - When `vc > GRID_YF`, hold `row`/`yoff` at 0.
- `in_grid` = `synced` AND `GRID_XI ≤ hc ≤ GRID_XF` AND `GRID_YI ≤ vc ≤ GRID_YF`.
- `lines`, only when `in_grid`:
  - `xoff < LINE_W`, or
  - `yoff < LINE_W`, or
  - last column and `xoff ≥ CELL_W − LINE_W`, or
  - last row and `yoff ≥ CELL_H − LINE_W`.
- When `in_grid` = 0:
  - `matrix_x = 0`, `matrix_y = 0`.
  - `lines = 0`, `cell_sel = 0`.
- Reset, including mid-frame:
  - All counters and outputs clear to 0, and `synced` clears.
  - `in_grid` stays 0 until the next frame start (`hc == GRID_XI`, `vc == GRID_YI`) is seen after `rst` deasserts.
  - A partially tracked frame is never displayed.
- Counter widths:
  - `xoff` is $clog2(`CELL_W`) bits and `yoff` is $clog2(`CELL_H`) bits.
  - `col`/`row` never exceed `N_COLS − 1`/`N_ROWS − 1` inside the grid, so there is no wrap at the index level.

## Timing
- All outputs are registered, with exactly 1 cycle of latency: outputs at cycle t+1 describe `hc`/`vc` at cycle t.
- Reset value of every output is 0. Reset takes effect immediately, asynchronously.
- `sel_x`/`sel_y` are sampled in the same cycle as `hc`/`vc`. A change takes effect on the next pixel, so no frame-boundary synchronisation is required.
- If the frame-start condition and `rst` deassertion coincide, the frame start is seen: `synced` sets on that edge.

## Configuration
- `GRID_HIGHLIGHT_EN` defined:
  - `cell_sel` = `in_grid` AND `col == sel_x` AND `row == sel_y`, registered with the same latency as the other outputs.
- `GRID_HIGHLIGHT_EN` undefined:
  - `cell_sel` is tied to 0 and `sel_x`/`sel_y` are ignored.
  - The comparators and register are not built; the ports remain so the interface is unchanged.

## Test plan
All scenarios use default parameters after one synced frame unless stated.
1. Frame start: `hc = 212`, `vc = 184` → next cycle `in_grid = 1`, `matrix_x = 0`, `matrix_y = 0`, `lines = 1`.
2. Column boundary at `vc = 250`:
   - `hc = 311` → `matrix_x = 0`, `lines = 0`.
   - `hc = 312` → `matrix_x = 1`, `lines = 1`.
   - `hc = 313` → `lines = 0`.
3. Right and bottom edges:
   - `hc = 811` → `matrix_x = 5`, `lines = 1`; `hc = 812` → `in_grid = 0`, `lines = 0`.
   - `vc = 583` → `matrix_y = 3`, `lines = 1` across the row.
4. Mid-frame reset:
   - Pulse `rst` at `vc = 300`, then sweep to frame end → `in_grid = 0` for the rest of that frame.
   - Next frame at `vc = 184` → `in_grid = 1`.
5. Highlight with `sel_x = 2`, `sel_y = 1`:
   - `hc = 450`, `vc = 330` → `cell_sel = 1`.
   - `hc = 420`, same `vc` (column 2) with `sel_x = 3` → `cell_sel = 0`.
   - With the macro undefined → always 0.
6. `LINE_W = 3`, `N_COLS = 3`, `CELL_W = 40`:
   - `xoff = 0..2` → `lines = 1`; `xoff = 3` → `lines = 0` (off a horizontal line).
   - Last column `xoff = 37..39` → `lines = 1`; `matrix_x` reaches 2 and never 3.
